// File: rtl/rhs_pkg.sv
// Shared state encoding, register map and command-word builder for the RHS stimulation sequencer.
package rhs_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_POL_A,
      ST_ON,
      ST_WAIT_A,
      ST_POL_B,
      ST_WAIT_B,
      ST_OFF,
      ST_IPD,
      ST_DONE
   } state_t;

   localparam logic [1:0] OP_WRITE     = 2'b10;
   localparam logic [7:0] REG_STIM_POL = 8'd44;
   localparam logic [7:0] REG_STIM_ON  = 8'd42;

   function automatic logic [31:0] rhs_wr(input logic u, input logic [7:0] addr,
                                          input logic [15:0] data);
      return {OP_WRITE, u, 1'b0, 4'h0, addr, data};
   endfunction

endpackage

// File: rtl/rhs_stim_sequencer_if.sv
// Command-word handshake towards the RHS SPI engine.
interface rhs_stim_sequencer_if #(
   parameter int CMD_W = 32
);
   logic             cmd_valid;
   logic             cmd_ready;
   logic [CMD_W-1:0] cmd_data;

   modport master (output cmd_valid, output cmd_data, input cmd_ready);
   modport slave  (input cmd_valid, input cmd_data, output cmd_ready);
endinterface

// File: rtl/rhs_tick_gen.sv
// Stim-tick prescaler: one tick every TICK_DIV aclk cycles, phase restarted by clr.
module rhs_tick_gen #(
   parameter int TICK_DIV = 2800
) (
   input  logic aclk,
   input  logic areset,
   input  logic clr,
   output logic tick
);
   localparam int            CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge aclk) begin
      if (areset || clr || cnt == LAST) cnt <= '0;
      else                              cnt <= cnt + 1'b1;
   end

   assign tick = (cnt == LAST) && !clr;

endmodule

// File: rtl/rhs_stim_sequencer.sv
// Biphasic stimulation train sequencer emitting RHS SPI write words.
// Optional build macro RHS_STIM_INFINITE_EN enables cfg_inf (train runs until abort).
module rhs_stim_sequencer
   import rhs_pkg::*;
#(
   parameter int TICK_DIV = 2800,
   parameter int CMD_W    = 32
) (
   input  logic                 aclk,
   input  logic                 areset,
   input  logic                 start,
   input  logic                 abort,
   input  logic [4:0]           cfg_pos_ch,
   input  logic [4:0]           cfg_neg_ch,
   input  logic                 cfg_mono,
   input  logic [15:0]          cfg_pw,
   input  logic [15:0]          cfg_ipd,
   input  logic [9:0]           cfg_npulse,
   input  logic                 cfg_inf,
   rhs_stim_sequencer_if.master cmd,
   output logic                 busy,
   output logic                 done,
   output logic                 aborted,
   output logic [9:0]           pulse_cnt
);

   state_t      state, nxt;
   logic        start_q, launch, active, xfer, abrt, tick;
   logic        cmd_vld, fin, last_now, wait_end, ipd_end;
   logic [31:0] word;
   logic [3:0]  pos_q, neg_q;
   logic        mono_q;
   logic [15:0] pw_q, ipd_q, pw_eff, tmr, pos_bit, mask;
   logic [16:0] tmr_nxt;
   logic [9:0]  npulse_q;

   // Stim registers are 16 bits wide, so only the low nibble picks the electrode bit.
   logic unused_ch;
   assign unused_ch = cfg_pos_ch[4] ^ cfg_neg_ch[4];

`ifdef RHS_STIM_INFINITE_EN
   logic inf_q;
   always_ff @(posedge aclk) begin
      if (areset)      inf_q <= 1'b0;
      else if (launch) inf_q <= cfg_inf;
   end
`else
   logic inf_q;
   logic unused_inf;
   assign inf_q      = 1'b0;
   assign unused_inf = cfg_inf;
`endif

   assign launch   = start && !start_q && (state == ST_IDLE);
   assign active   = (state != ST_IDLE) && (state != ST_DONE);
   assign xfer     = cmd_vld && cmd.cmd_ready;
   assign abrt     = abort || aborted;
   assign last_now = !inf_q && (pulse_cnt == npulse_q);

   assign pos_bit = 16'h0001 << pos_q;
   assign mask    = mono_q ? pos_bit : (pos_bit | (16'h0001 << neg_q));

   rhs_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
      .aclk   (aclk),
      .areset (areset),
      .clr    (xfer),
      .tick   (tick)
   );

   // Phase timer counts ticks since the last word transfer.
   assign pw_eff   = (pw_q == 16'd0) ? 16'd1 : pw_q;
   assign tmr_nxt  = {1'b0, tmr} + 17'd1;
   assign wait_end = tick && (tmr_nxt >= {1'b0, pw_eff});
   assign ipd_end  = tick && (tmr_nxt >= {1'b0, ipd_q});

   always_ff @(posedge aclk) begin
      if (areset) state <= ST_IDLE;
      else        state <= nxt;
   end

   always_comb begin
      nxt = state;
      case (state)
         ST_IDLE:   if (launch) nxt = ST_POL_A;
         ST_POL_A:  if (xfer) nxt = abrt ? ST_OFF : ST_ON;
         ST_ON:     if (xfer) nxt = abrt ? ST_OFF : ST_WAIT_A;
         ST_WAIT_A: if (abrt) nxt = ST_OFF; else if (wait_end) nxt = ST_POL_B;
         ST_POL_B:  if (xfer) nxt = abrt ? ST_OFF : ST_WAIT_B;
         ST_WAIT_B: if (abrt || wait_end) nxt = ST_OFF;
         ST_OFF: begin
            if (xfer) begin
               if (abrt)                nxt = ST_DONE;
               else if (ipd_q != 16'd0) nxt = ST_IPD;
               else                     nxt = last_now ? ST_DONE : ST_POL_A;
            end
         end
         ST_IPD: begin
            if (abrt || (ipd_end && fin)) nxt = ST_DONE;
            else if (ipd_end)             nxt = ST_POL_A;
         end
         ST_DONE:   if (!start) nxt = ST_IDLE;
         default:   nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      cmd_vld = 1'b0;
      word    = '0;
      case (state)
         ST_POL_A: begin cmd_vld = 1'b1; word = rhs_wr(1'b0, REG_STIM_POL, pos_bit);         end
         ST_ON:    begin cmd_vld = 1'b1; word = rhs_wr(1'b1, REG_STIM_ON, mask);             end
         ST_POL_B: begin cmd_vld = 1'b1; word = rhs_wr(1'b1, REG_STIM_POL, mask & ~pos_bit); end
         ST_OFF:   begin cmd_vld = 1'b1; word = rhs_wr(1'b1, REG_STIM_ON, 16'h0000);         end
         default:  ;
      endcase
      busy = (state != ST_IDLE);
      done = (state == ST_DONE);
   end

   assign cmd.cmd_valid = cmd_vld;
   assign cmd.cmd_data  = CMD_W'(word);

   always_ff @(posedge aclk) begin
      if (areset) begin
         start_q   <= 1'b0;
         pos_q     <= '0;
         neg_q     <= '0;
         mono_q    <= 1'b0;
         pw_q      <= '0;
         ipd_q     <= '0;
         npulse_q  <= '0;
         pulse_cnt <= '0;
         aborted   <= 1'b0;
         fin       <= 1'b0;
         tmr       <= '0;
      end else begin
         start_q <= start;
         if (launch) begin
            pos_q     <= cfg_pos_ch[3:0];
            neg_q     <= cfg_neg_ch[3:0];
            mono_q    <= cfg_mono;
            pw_q      <= cfg_pw;
            ipd_q     <= cfg_ipd;
            npulse_q  <= cfg_npulse;
            pulse_cnt <= '0;
            aborted   <= 1'b0;
            fin       <= 1'b0;
         end
         if (abort && active) aborted <= 1'b1;
         if (state == ST_OFF && xfer) begin
            if (pulse_cnt != 10'h3FF) pulse_cnt <= pulse_cnt + 10'd1;
            fin <= last_now;
         end
         if (xfer)      tmr <= '0;
         else if (tick) tmr <= tmr + 16'd1;
      end
   end

endmodule

// File: tb/tb_rhs_stim_sequencer.sv
// Scoreboard bench for rhs_stim_sequencer: expected words and inter-transfer gaps are queued by the stimulus, a monitor checks each transfer.
module tb_rhs_stim_sequencer;
   localparam int TD = 4;

   logic       aclk = 1'b0;
   logic       areset, start, abort, cfg_mono, cfg_inf;
   logic [4:0] cfg_pos_ch, cfg_neg_ch;
   logic [15:0] cfg_pw, cfg_ipd;
   logic [9:0] cfg_npulse;
   logic       busy, done, aborted;
   logic [9:0] pulse_cnt;

   rhs_stim_sequencer_if #(.CMD_W(32)) cmd ();

   rhs_stim_sequencer #(.TICK_DIV(TD), .CMD_W(32)) dut (
      .aclk       (aclk),
      .areset     (areset),
      .start      (start),
      .abort      (abort),
      .cfg_pos_ch (cfg_pos_ch),
      .cfg_neg_ch (cfg_neg_ch),
      .cfg_mono   (cfg_mono),
      .cfg_pw     (cfg_pw),
      .cfg_ipd    (cfg_ipd),
      .cfg_npulse (cfg_npulse),
      .cfg_inf    (cfg_inf),
      .cmd        (cmd),
      .busy       (busy),
      .done       (done),
      .aborted    (aborted),
      .pulse_cnt  (pulse_cnt)
   );

   always #5 aclk = ~aclk;

   typedef struct {
      logic [31:0] data;
      int          gap;   // cycles since previous transfer; 0 = not checked
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0, failures = 0;
   int   cyc = 0, last_cyc = 0, xfers = 0;
   bit   sb_en = 1'b1;

   task automatic chk_w(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s got=%h want=%h", name, got, want);
      end
   endtask

   task automatic chk_b(input string name, input logic got, input logic want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s got=%b want=%b", name, got, want);
      end
   endtask

   task automatic push(input logic [31:0] d, input int g);
      exp_t e;
      e.data = d;
      e.gap  = g;
      exp_q.push_back(e);
   endtask

   task automatic cyc_wait(input int n);
      repeat (n) begin
         @(posedge aclk);
         #1;
      end
   endtask

   task automatic set_cfg(input logic [4:0] p, input logic [4:0] n, input logic mono,
                          input logic [15:0] pw, input logic [15:0] ipd,
                          input logic [9:0] np, input logic inf);
      cfg_pos_ch = p;  cfg_neg_ch = n;  cfg_mono = mono;
      cfg_pw = pw;     cfg_ipd = ipd;   cfg_npulse = np;  cfg_inf = inf;
   endtask

   task automatic wait_done(input int maxc);
      int k = 0;
      while (!done && k < maxc) begin
         cyc_wait(1);
         k++;
      end
      chk_b("done_seen", done, 1'b1);
   endtask

   task automatic wait_xfers(input int target, input int maxc);
      int k = 0;
      while (xfers < target && k < maxc) begin
         cyc_wait(1);
         k++;
      end
      chk_b("xfer_seen", xfers >= target, 1'b1);
   endtask

   task automatic finish_train;
      start = 1'b0;
      cyc_wait(1);
      chk_b("done_drop", done, 1'b0);
      chk_b("busy_drop", busy, 1'b0);
   endtask

   // Monitor: every accepted word is compared against the head of the scoreboard.
   initial forever begin
      exp_t e;
      @(negedge aclk);
      cyc++;
      if (cmd.cmd_valid && cmd.cmd_ready) begin
         xfers++;
         if (sb_en) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL extra_word got=%h want=none", cmd.cmd_data);
            end else begin
               e = exp_q.pop_front();
               chk_w("cmd_word", cmd.cmd_data, e.data);
               if (e.gap != 0) chk_w("xfer_gap", cyc - last_cyc, e.gap);
            end
         end
         last_cyc = cyc;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1);
   end

   initial begin
      int base;
      int k;
      areset = 1'b1; start = 1'b0; abort = 1'b0; cmd.cmd_ready = 1'b1;
      set_cfg(5'd0, 5'd0, 1'b1, 16'd0, 16'd0, 10'd0, 1'b0);
      cyc_wait(3);
      areset = 1'b0;
      cyc_wait(1);
      chk_b("rst_busy", busy, 1'b0);
      chk_b("rst_done", done, 1'b0);
      chk_b("rst_aborted", aborted, 1'b0);
      chk_w("rst_pulse_cnt", 32'(pulse_cnt), 32'd0);
      chk_b("rst_valid", cmd.cmd_valid, 1'b0);
      chk_w("rst_data", cmd.cmd_data, 32'h0);

      // Bipolar 17/18, two pulses, 16-tick interpulse delay; cfg scrambled after launch.
      for (int p = 0; p < 2; p++) begin
         push(32'h802C0002, (p == 0) ? 0 : 65);
         push(32'hA02A0006, 1);
         push(32'hA02C0004, 5);
         push(32'hA02A0000, 5);
      end
      set_cfg(5'd17, 5'd18, 1'b0, 16'd1, 16'd16, 10'd1, 1'b0);
      start = 1'b1;
      cyc_wait(1);
      set_cfg(5'd0, 5'd9, 1'b1, 16'd7, 16'd0, 10'd0, 1'b0);
      chk_b("t1_busy", busy, 1'b1);
      wait_done(400);
      chk_w("t1_pulse_cnt", 32'(pulse_cnt), 32'd2);
      chk_b("t1_aborted", aborted, 1'b0);
      chk_w("t1_words_left", exp_q.size(), 32'd0);
      cyc_wait(10);
      chk_b("t1_done_hold", done, 1'b1);
      chk_b("t1_busy_hold", busy, 1'b1);
      finish_train;

      // Monopolar ch3, pw=0 behaves as one tick.
      push(32'h802C0008, 0);
      push(32'hA02A0008, 1);
      push(32'hA02C0000, 5);
      push(32'hA02A0000, 5);
      set_cfg(5'd3, 5'd5, 1'b1, 16'd0, 16'd0, 10'd0, 1'b0);
      start = 1'b1;
      cyc_wait(1);
      wait_done(100);
      chk_w("t2_pulse_cnt", 32'(pulse_cnt), 32'd1);
      chk_w("t2_words_left", exp_q.size(), 32'd0);
      finish_train;

      // Bipolar with pos==neg, ON word stalled by cmd_ready low for 10 cycles.
      push(32'h802C0010, 0);
      push(32'hA02A0010, 11);
      push(32'hA02C0000, 9);
      push(32'hA02A0000, 9);
      cmd.cmd_ready = 1'b0;
      set_cfg(5'd4, 5'd4, 1'b0, 16'd2, 16'd0, 10'd0, 1'b0);
      start = 1'b1;
      cyc_wait(3);
      cmd.cmd_ready = 1'b1;
      cyc_wait(1);
      cmd.cmd_ready = 1'b0;
      for (int i = 0; i < 10; i++) begin
         chk_b("stall_valid", cmd.cmd_valid, 1'b1);
         chk_w("stall_data", cmd.cmd_data, 32'hA02A0010);
         cyc_wait(1);
      end
      cmd.cmd_ready = 1'b1;
      wait_done(100);
      chk_w("t3_pulse_cnt", 32'(pulse_cnt), 32'd1);
      chk_w("t3_words_left", exp_q.size(), 32'd0);
      finish_train;

      // Abort during WAIT_B of the first of three pulses.
      base = xfers;
      push(32'h802C0001, 0);
      push(32'hA02A8001, 1);
      push(32'hA02C8000, 17);
      push(32'hA02A0000, 5);
      set_cfg(5'd0, 5'd15, 1'b0, 16'd4, 16'd2, 10'd2, 1'b0);
      start = 1'b1;
      cyc_wait(1);
      wait_xfers(base + 3, 100);
      cyc_wait(3);
      abort = 1'b1;
      cyc_wait(1);
      abort = 1'b0;
      wait_done(100);
      chk_b("t4_aborted", aborted, 1'b1);
      chk_w("t4_pulse_cnt", 32'(pulse_cnt), 32'd1);
      cyc_wait(5);
      chk_w("t4_words_left", exp_q.size(), 32'd0);
      finish_train;
      chk_b("t4_aborted_hold", aborted, 1'b1);
      chk_w("t4_cnt_hold", 32'(pulse_cnt), 32'd1);

      // Reset mid-train: valid drops at once, no OFF word follows.
      base = xfers;
      push(32'h802C0004, 0);
      push(32'hA02A0004, 1);
      set_cfg(5'd2, 5'd0, 1'b1, 16'd3, 16'd0, 10'd0, 1'b0);
      start = 1'b1;
      cyc_wait(1);
      chk_b("t5_aborted_clr", aborted, 1'b0);
      wait_xfers(base + 2, 50);
      cyc_wait(2);
      areset = 1'b1;
      start  = 1'b0;
      cyc_wait(1);
      areset = 1'b0;
      chk_b("t5_valid", cmd.cmd_valid, 1'b0);
      chk_b("t5_busy", busy, 1'b0);
      chk_w("t5_pulse_cnt", 32'(pulse_cnt), 32'd0);
      cyc_wait(30);
      chk_w("t5_words_left", exp_q.size(), 32'd0);
      chk_b("t5_idle", busy, 1'b0);

      // Infinite request: honoured only when the feature is built in.
      sb_en = 1'b0;
      set_cfg(5'd1, 5'd2, 1'b0, 16'd0, 16'd0, 10'd0, 1'b1);
      start = 1'b1;
      cyc_wait(1);
`ifdef RHS_STIM_INFINITE_EN
      k = 0;
      while (pulse_cnt <= 10'd6 && k < 600) begin
         cyc_wait(1);
         k++;
      end
      chk_b("inf_many", pulse_cnt > 10'd5, 1'b1);
      chk_b("inf_not_done", done, 1'b0);
      abort = 1'b1;
      cyc_wait(1);
      abort = 1'b0;
      wait_done(100);
      chk_b("inf_aborted", aborted, 1'b1);
`else
      k = 0;
      wait_done(100);
      chk_w("inf_off_cnt", 32'(pulse_cnt), 32'd1);
      chk_b("inf_off_aborted", aborted, 1'b0);
`endif
      finish_train;
      sb_en = 1'b1;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
